traffic_injector: RTL and testbench

Per-node packet injection controller for the NoC benchmark. It turns the free-running random word and the global send/cooldown phase into a paced stream of packet headers (destination, sequence number) using a valid/ready handshake toward the router's local port. It buffers bursts as a pending count and drains that count after send falls. It asserts done once the node is quiescent.

---
 rtl/traffic_injector.sv | 153 +++++++++++++++
 tb/tb_traffic_injector.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_injector.sv
// traffic_injector
//   Per-node packet injection controller. Compares the upper RATE_BITS of the
//   free-running random word against the rate threshold to decide whether a
//   packet is generated this cycle. Generated packets go straight into the
//   output slot when it is free. Otherwise they are counted in a saturating
//   backlog, which keeps draining after the send phase ends. done is raised
//   once the node is quiescent.
//
// Ports
//   clk, reset   clock; asynchronous active-high reset
//   send         injection phase (1 = generate, 0 = cooldown/drain)
//   rand_word    random word, new value every cycle (the spec names this
//                port "rand", but rand is a reserved SystemVerilog keyword)
//   rate         generation threshold; probability = rate / 2**RATE_BITS
//   out_valid    header valid toward the router local port
//   out_ready    router accepts the header
//   out_dest     destination node, never NODE_ID
//   out_seq      per-node sequence number, starts at 0 after reset
//   backlog      generated packets not yet loaded into the output slot
//   inj_count    accepted handshakes, saturating
//   drop_count   generations lost to a full backlog, saturating
//   done         high while the FSM is in DONE
module traffic_injector #(
  parameter int NODES       = 9,
  parameter int NODE_ID     = 0,
  parameter int DEST_BITS   = 4,
  parameter int RAND_BITS   = 32,
  parameter int RATE_BITS   = 8,
  parameter int SEQ_BITS    = 8,
  parameter int CNT_BITS    = 16,
  parameter int MAX_BACKLOG = 15,
  parameter int BL_BITS     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 send,
  input  logic [RAND_BITS-1:0] rand_word,
  input  logic [RATE_BITS-1:0] rate,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DEST_BITS-1:0] out_dest,
  output logic [SEQ_BITS-1:0]  out_seq,
  output logic [BL_BITS-1:0]   backlog,
  output logic [CNT_BITS-1:0]  inj_count,
  output logic [CNT_BITS-1:0]  drop_count,
  output logic                 done
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

  // Parameter values sized to the signals they are compared with.
  localparam logic [DEST_BITS:0]  NODES_V = NODES[DEST_BITS:0];
  localparam logic [DEST_BITS:0]  ID_V    = NODE_ID[DEST_BITS:0];
  localparam logic [DEST_BITS:0]  D_ONE   = 1;
  localparam logic [BL_BITS:0]    MAX_BLW = MAX_BACKLOG[BL_BITS:0];
  localparam logic [BL_BITS-1:0]  MAX_BL  = MAX_BACKLOG[BL_BITS-1:0];
  localparam logic [BL_BITS-1:0]  BL_ONE  = 1;
  localparam logic [SEQ_BITS-1:0] SEQ_ONE = 1;
  localparam logic [CNT_BITS-1:0] CNT_ONE = 1;

  state_t               state, state_next;
  logic                 gen, slot_free, accept, load, drop;
  logic [BL_BITS:0]     bl_sum;
  logic [BL_BITS-1:0]   backlog_next;
  logic [DEST_BITS:0]   fold_d;
  logic [DEST_BITS-1:0] dest_fold;
  logic [SEQ_BITS-1:0]  next_seq;

  assign gen       = (state == ST_RUN) && (rand_word[RAND_BITS-1 -: RATE_BITS] < rate);
  assign slot_free = !out_valid || out_ready;
  assign accept    = out_valid && out_ready;
  assign bl_sum    = {1'b0, backlog} + {{BL_BITS{1'b0}}, gen};

  // Fold the raw field into 0..NODES-1 and skip our own index.
  // The raw field is below 2*NODES, so one subtraction is enough.
  always_comb begin
    fold_d = {1'b0, rand_word[DEST_BITS-1:0]};
    if (fold_d >= NODES_V) fold_d = fold_d - NODES_V;
    if (fold_d == ID_V)    fold_d = fold_d + D_ONE;
    if (fold_d == NODES_V) fold_d = '0;
    dest_fold = fold_d[DEST_BITS-1:0];
  end

  // Slot loading and backlog bookkeeping.
  // NOTE: every signal gets a default at the top of the block so no path
  // leaves it unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    load         = 1'b0;
    drop         = 1'b0;
    backlog_next = backlog;
    if (slot_free) begin
      if (backlog != '0) begin
        // One leaves for the slot, and a fresh generation replaces it.
        load         = 1'b1;
        backlog_next = gen ? backlog : backlog - BL_ONE;
      end else if (gen) begin
        load = 1'b1;
      end
    end else if (bl_sum > MAX_BLW) begin
      backlog_next = MAX_BL;
      drop         = 1'b1;
    end else begin
      backlog_next = bl_sum[BL_BITS-1:0];
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (send) state_next = ST_RUN;
      ST_RUN:   if (!send) state_next = ST_DRAIN;
      ST_DRAIN: begin
        if (send)
          state_next = ST_RUN;
        else if (backlog == '0 && (!out_valid || accept))
          state_next = ST_DONE;
      end
      ST_DONE:  if (send) state_next = ST_RUN;
      default:  state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      out_valid  <= 1'b0;
      out_dest   <= '0;
      out_seq    <= '0;
      next_seq   <= '0;
      backlog    <= '0;
      inj_count  <= '0;
      drop_count <= '0;
      done       <= 1'b0;
    end else begin
      state   <= state_next;
      done    <= (state_next == ST_DONE);
      backlog <= backlog_next;
      if (slot_free) out_valid <= load;
      // dest and seq change only on a load, which gives the hold-under-stall
      // behaviour for free.
      if (load) begin
        out_dest <= dest_fold;
        out_seq  <= next_seq;
        next_seq <= next_seq + SEQ_ONE;
      end
      if (accept && inj_count != '1) inj_count <= inj_count + CNT_ONE;
      if (drop && drop_count != '1)  drop_count <= drop_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_traffic_injector.sv
// tb_traffic_injector
//   Drives traffic_injector with directed and randomized stimulus and compares
//   every output, every cycle, against a behavioural model that keeps the
//   node state in plain integers. A second instance with NODE_ID=8 shares
//   all inputs and is used only for its destination fold.
module tb_traffic_injector;

  localparam int NODES = 9;
  localparam int MAXBL = 15;
  localparam int CMAX  = 65535;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        send = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] rand_word = '0;
  logic [7:0]  rate = '0;

  logic        out_valid, out_valid_b;
  logic [3:0]  out_dest, out_dest_b;
  logic [7:0]  out_seq, out_seq_b;
  logic [3:0]  backlog, backlog_b;
  logic [15:0] inj_count, inj_count_b, drop_count, drop_count_b;
  logic        done, done_b;

  traffic_injector #(.NODES(9), .NODE_ID(4)) u_dut (
    .clk(clk), .reset(reset), .send(send), .rand_word(rand_word), .rate(rate),
    .out_valid(out_valid), .out_ready(out_ready), .out_dest(out_dest),
    .out_seq(out_seq), .backlog(backlog), .inj_count(inj_count),
    .drop_count(drop_count), .done(done)
  );

  traffic_injector #(.NODES(9), .NODE_ID(8)) u_dut_b (
    .clk(clk), .reset(reset), .send(send), .rand_word(rand_word), .rate(rate),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_dest(out_dest_b),
    .out_seq(out_seq_b), .backlog(backlog_b), .inj_count(inj_count_b),
    .drop_count(drop_count_b), .done(done_b)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int m_state, m_valid, m_dest4, m_dest8, m_seq, m_next;
  int m_bl, m_inj, m_drop, m_done;
  int hs_seq;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int fold(input int raw, input int id);
    int d;
    d = raw % NODES;
    if (d == id) d = (d + 1) % NODES;
    return d;
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_valid = 0; m_dest4 = 0; m_dest8 = 0; m_seq = 0;
    m_next = 0; m_bl = 0; m_inj = 0; m_drop = 0; m_done = 0; hs_seq = 0;
  endtask

  // Applies one clock edge to the model using the inputs held across it.
  task automatic model_edge();
    int gen, acc, old_state, old_bl, old_valid;
    if (reset) begin
      model_reset();
      return;
    end
    old_state = m_state; old_bl = m_bl; old_valid = m_valid;
    gen = (m_state == M_RUN && int'(rand_word[31:24]) < int'(rate)) ? 1 : 0;
    acc = (m_valid != 0 && out_ready) ? 1 : 0;
    if (m_valid == 0 || out_ready) begin
      if (m_bl > 0 || gen != 0) begin
        if (m_bl > 0) m_bl = m_bl - 1 + gen;
        m_valid = 1;
        m_dest4 = fold(int'(rand_word[3:0]), 4);
        m_dest8 = fold(int'(rand_word[3:0]), 8);
        m_seq   = m_next;
        m_next  = (m_next + 1) % 256;
      end else begin
        m_valid = 0;
      end
    end else if (m_bl + gen > MAXBL) begin
      m_bl = MAXBL;
      if (m_drop < CMAX) m_drop++;
    end else begin
      m_bl = m_bl + gen;
    end
    if (acc != 0 && m_inj < CMAX) m_inj++;
    case (old_state)
      M_IDLE:  if (send) m_state = M_RUN;
      M_RUN:   if (!send) m_state = M_DRAIN;
      M_DRAIN: if (send) m_state = M_RUN;
               else if (old_bl == 0 && (old_valid == 0 || acc != 0)) m_state = M_DONE;
      default: if (send) m_state = M_RUN;
    endcase
    m_done = (m_state == M_DONE) ? 1 : 0;
  endtask

  task automatic compare_all();
    check("out_valid",  int'(out_valid),  m_valid);
    check("out_dest",   int'(out_dest),   m_dest4);
    check("out_dest_b", int'(out_dest_b), m_dest8);
    check("out_seq",    int'(out_seq),    m_seq);
    check("backlog",    int'(backlog),    m_bl);
    check("inj_count",  int'(inj_count),  m_inj);
    check("drop_count", int'(drop_count), m_drop);
    check("done",       int'(done),       m_done);
  endtask

  // Called just after a falling edge: drive inputs, see through one rising
  // edge, then compare on the next falling edge.
  task automatic step(input logic s, input logic rdy, input logic [31:0] rw,
                      input logic [7:0] rt);
    send = s; out_ready = rdy; rand_word = rw; rate = rt;
    #1;
    if (!reset && out_valid && out_ready) begin
      check("hs_seq", int'(out_seq), hs_seq % 256);
      hs_seq++;
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b1, 1'b0, $urandom, 8'd0);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    logic        s;
    int          ready_pct;
    logic [7:0]  rt;

    model_reset();
    @(negedge clk);

    // Reset held for two cycles with send high.
    reset = 1'b1;
    step(1'b1, 1'b0, 32'h0, 8'd200);
    step(1'b1, 1'b0, 32'h0, 8'd200);
    reset = 1'b0;

    // Zero rate: nothing is ever generated.
    for (int i = 0; i < 100; i++) step(1'b1, 1'b1, $urandom, 8'd0);
    check("zero_rate_inj", int'(inj_count), 0);
    step(1'b0, 1'b1, $urandom, 8'd0);
    step(1'b0, 1'b1, $urandom, 8'd0);
    check("zero_rate_done", int'(done), 1);

    // Destination fold on consecutive loads.
    step(1'b1, 1'b1, 32'h0, 8'd255);
    step(1'b1, 1'b1, 32'h0000_0004, 8'd255);
    check("fold_4", int'(out_dest), 5);
    step(1'b1, 1'b1, 32'h0000_000C, 8'd255);
    check("fold_12", int'(out_dest), 3);
    step(1'b1, 1'b1, 32'h0000_000D, 8'd255);
    check("fold_13", int'(out_dest), 5);
    step(1'b1, 1'b1, 32'h0000_0008, 8'd255);
    check("fold_8", int'(out_dest), 8);
    check("fold_8_id8", int'(out_dest_b), 0);

    // Backpressure: generate every cycle with the router stalled.
    do_reset();
    step(1'b1, 1'b0, 32'h0, 8'd0);
    for (int k = 1; k <= 20; k++) begin
      r = $urandom;
      step(1'b1, 1'b0, {8'h00, r[23:0]}, 8'd255);
      if (k == 16) begin
        check("bp_backlog_16", int'(backlog), 15);
        check("bp_drop_16", int'(drop_count), 0);
      end
    end
    check("bp_drop_20", int'(drop_count), 4);
    check("bp_seq_held", int'(out_seq), 0);

    // Drain after send falls.
    for (int k = 0; k < 40 && !done; k++) begin
      r = $urandom;
      step(1'b0, 1'b1, {8'hFF, r[23:0]}, 8'd255);
    end
    check("drain_hs", hs_seq, 16);
    check("drain_inj", int'(inj_count), 16);
    check("drain_backlog", int'(backlog), 0);
    check("drain_done", int'(done), 1);

    // Backlog of 3 with generation and acceptance in the same cycle.
    do_reset();
    step(1'b1, 1'b0, 32'h0, 8'd0);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, $urandom & 32'h00FF_FFFF, 8'd255);
    check("sim_backlog_pre", int'(backlog), 3);
    step(1'b1, 1'b1, $urandom & 32'h00FF_FFFF, 8'd255);
    check("sim_backlog", int'(backlog), 3);
    check("sim_seq", int'(out_seq), 1);
    step(1'b1, 1'b0, $urandom & 32'h00FF_FFFF, 8'd255);

    // Reset in the middle of a burst clears everything at once.
    reset = 1'b1;
    #1;
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_backlog", int'(backlog), 0);
    check("mid_rst_seq", int'(out_seq), 0);
    check("mid_rst_inj", int'(inj_count), 0);
    check("mid_rst_drop", int'(drop_count), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // Randomized traffic with phase changes and varying backpressure.
    s = 1'b1; rt = 8'd128; ready_pct = 70;
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) begin
        case ($urandom_range(0, 3))
          0:       rt = 8'd0;
          1:       rt = 8'd255;
          default: rt = 8'($urandom);
        endcase
        ready_pct = $urandom_range(10, 100);
      end
      if ($urandom_range(0, 24) == 0) s = ~s;
      step(s, ($urandom_range(1, 100) <= ready_pct), $urandom, rt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
